// File: rtl/lsu_pkg.sv
// Shared constants for the multi-cycle load/store unit: funct3 codes, FSM states, lane masks.
package lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_ACC1 = 3'd1;
    localparam logic [2:0] ST_ACC2 = 3'd2;
    localparam logic [2:0] ST_ERR  = 3'd3;
    localparam logic [2:0] ST_RESP = 3'd4;

    localparam logic [3:0] MASK_B = 4'b0001;
    localparam logic [3:0] MASK_H = 4'b0011;
    localparam logic [3:0] MASK_W = 4'b1111;

    function automatic logic [3:0] size_mask(input logic [1:0] size);
        case (size)
            2'b00:   return MASK_B;
            2'b01:   return MASK_H;
            default: return MASK_W;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane alignment: byte mask and store shift for either beat, load shift + extension.
// Zero latency; no flow control of its own.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_off,
    input  logic        i_beat2,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata_lo,
    input  logic [23:0] i_rdata_hi,
    output logic [3:0]  o_mask,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);

    logic [7:0]  w_mask8;
    logic [63:0] w_wdata64;
    logic [31:0] w_shr;

    always_comb begin
        w_mask8   = {4'b0000, size_mask(i_funct3[1:0])} << i_off;
        w_wdata64 = {32'd0, i_wdata} << {i_off, 3'b000};
        o_mask    = i_beat2 ? w_mask8[7:4] : w_mask8[3:0];
        o_wdata   = i_beat2 ? w_wdata64[63:32] : w_wdata64[31:0];

        // Only the low 24 bits of the upper word can ever land in the result.
        case (i_off)
            2'd0:    w_shr = i_rdata_lo;
            2'd1:    w_shr = {i_rdata_hi[7:0],  i_rdata_lo[31:8]};
            2'd2:    w_shr = {i_rdata_hi[15:0], i_rdata_lo[31:16]};
            default: w_shr = {i_rdata_hi[23:0], i_rdata_lo[31:24]};
        endcase

        case (i_funct3)
            F3_LB:   o_rdata = {{24{w_shr[7]}}, w_shr[7:0]};
            F3_LH:   o_rdata = {{16{w_shr[15]}}, w_shr[15:0]};
            F3_LBU:  o_rdata = {24'd0, w_shr[7:0]};
            F3_LHU:  o_rdata = {16'd0, w_shr[15:0]};
            default: o_rdata = w_shr;
        endcase
    end

endmodule

// File: rtl/lsu_mc.sv
// Multi-cycle LSU: one request per transaction, response 2+ cycles after accept; ready only when idle.
// LSU_MISALIGNED_SPLIT_EN splits word-crossing accesses into two beats instead of trapping.
module lsu_mc #(
    parameter int ADDR_W   = 32,
    parameter int MAX_WAIT = 0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_we,
    input  logic [2:0]        i_req_funct3,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [31:0]       i_req_wdata,
    output logic              o_rsp_valid,
    output logic [31:0]       o_rsp_rdata,
    output logic              o_rsp_trap,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_ren,
    output logic              o_mem_wen,
    output logic [31:0]       o_mem_wdata,
    output logic [3:0]        o_mem_mask,
    input  logic              i_mem_done,
    input  logic [31:0]       i_mem_rdata
);
    import lsu_pkg::*;

    localparam int CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);
    localparam logic TIMEOUT_EN = (MAX_WAIT > 0);

    logic [2:0]        r_state;
    logic              r_we;
    logic [2:0]        r_f3;
    logic [1:0]        r_off;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_mem_ren, r_mem_wen;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [3:0]        r_mem_mask;
    logic [31:0]       r_mem_wdata;
    logic              r_rsp_valid, r_rsp_trap;
    logic [31:0]       r_rsp_rdata;

    logic              w_idle, w_illegal, w_err, w_more, w_timeout, w_beat2;
    logic [2:0]        w_f3;
    logic [1:0]        w_off;
    logic [31:0]       w_wdata, w_rd_lo, w_al_wdata, w_al_rdata;
    logic [23:0]       w_rd_hi;
    logic [3:0]        w_al_mask;

    assign w_idle    = (r_state == ST_IDLE);
    assign w_f3      = w_idle ? i_req_funct3 : r_f3;
    assign w_off     = w_idle ? i_req_addr[1:0] : r_off;
    assign w_illegal = (i_req_funct3 == 3'b011) || (i_req_funct3 == 3'b110) ||
                       (i_req_funct3 == 3'b111) || (i_req_we && i_req_funct3[2]);
    assign w_timeout = TIMEOUT_EN && (r_cnt == CNT_LAST);

`ifdef LSU_MISALIGNED_SPLIT_EN
    logic [31:0] r_wdata;
    logic [31:0] r_beat1;

    // While in ACC1 the aligner already presents beat-2 mask/data for the hand-over.
    assign w_wdata = w_idle ? i_req_wdata : r_wdata;
    assign w_beat2 = (r_state == ST_ACC1);
    assign w_rd_lo = (r_state == ST_ACC2) ? r_beat1 : i_mem_rdata;
    assign w_rd_hi = (r_state == ST_ACC2) ? i_mem_rdata[23:0] : 24'd0;
    assign w_err   = w_illegal;
    assign w_more  = (r_state == ST_ACC1) && (w_al_mask != 4'd0);
`else
    logic w_misal;

    assign w_misal = ((i_req_funct3[1:0] == 2'b01) && i_req_addr[0]) ||
                     ((i_req_funct3[1:0] == 2'b10) && (i_req_addr[1:0] != 2'b00));
    assign w_wdata = i_req_wdata;
    assign w_beat2 = 1'b0;
    assign w_rd_lo = i_mem_rdata;
    assign w_rd_hi = 24'd0;
    assign w_err   = w_illegal || w_misal;
    assign w_more  = 1'b0;
`endif

    lsu_align u_align (
        .i_funct3   (w_f3),
        .i_off      (w_off),
        .i_beat2    (w_beat2),
        .i_wdata    (w_wdata),
        .i_rdata_lo (w_rd_lo),
        .i_rdata_hi (w_rd_hi),
        .o_mask     (w_al_mask),
        .o_wdata    (w_al_wdata),
        .o_rdata    (w_al_rdata)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_we        <= 1'b0;
            r_f3        <= 3'd0;
            r_off       <= 2'd0;
            r_cnt       <= '0;
            r_mem_ren   <= 1'b0;
            r_mem_wen   <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_mask  <= 4'd0;
            r_mem_wdata <= 32'd0;
            r_rsp_valid <= 1'b0;
            r_rsp_trap  <= 1'b0;
            r_rsp_rdata <= 32'd0;
`ifdef LSU_MISALIGNED_SPLIT_EN
            r_wdata     <= 32'd0;
            r_beat1     <= 32'd0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: if (i_req_valid) begin
                    r_we  <= i_req_we;
                    r_f3  <= i_req_funct3;
                    r_off <= i_req_addr[1:0];
                    r_cnt <= '0;
`ifdef LSU_MISALIGNED_SPLIT_EN
                    r_wdata <= i_req_wdata;
`endif
                    if (w_err) begin
                        r_state <= ST_ERR;
                    end else begin
                        r_state     <= ST_ACC1;
                        r_mem_ren   <= ~i_req_we;
                        r_mem_wen   <= i_req_we;
                        r_mem_addr  <= {i_req_addr[ADDR_W-1:2], 2'b00};
                        r_mem_mask  <= w_al_mask;
                        r_mem_wdata <= i_req_we ? w_al_wdata : 32'd0;
                    end
                end
                ST_ACC1, ST_ACC2: begin
                    if (i_mem_done && w_more) begin
`ifdef LSU_MISALIGNED_SPLIT_EN
                        r_beat1 <= i_mem_rdata;
`endif
                        r_state     <= ST_ACC2;
                        r_cnt       <= '0;
                        r_mem_addr  <= r_mem_addr + ADDR_W'(4);
                        r_mem_mask  <= w_al_mask;
                        r_mem_wdata <= r_we ? w_al_wdata : 32'd0;
                    end else if (i_mem_done || w_timeout) begin
                        // A done in the limit cycle takes priority over the timeout.
                        r_state     <= ST_RESP;
                        r_mem_ren   <= 1'b0;
                        r_mem_wen   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_trap  <= ~i_mem_done;
                        r_rsp_rdata <= (i_mem_done && !r_we) ? w_al_rdata : 32'd0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_ERR: begin
                    r_state     <= ST_RESP;
                    r_rsp_valid <= 1'b1;
                    r_rsp_trap  <= 1'b1;
                    r_rsp_rdata <= 32'd0;
                end
                ST_RESP: begin
                    r_state     <= ST_IDLE;
                    r_rsp_valid <= 1'b0;
                    r_rsp_trap  <= 1'b0;
                    r_rsp_rdata <= 32'd0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_req_ready = w_idle;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_rdata = r_rsp_rdata;
    assign o_rsp_trap  = r_rsp_trap;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_ren   = r_mem_ren;
    assign o_mem_wen   = r_mem_wen;
    assign o_mem_wdata = r_mem_wdata;
    assign o_mem_mask  = r_mem_mask;

endmodule

// File: tb/tb_lsu_mc.sv
// Scoreboard bench for lsu_mc: byte-level reference memory predicts beats and responses.
`timescale 1ns/1ps
module tb_lsu_mc;
    localparam int MAXW  = 4;
    localparam int NEVER = 50;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_req_valid = 1'b0, i_req_we = 1'b0;
    logic [2:0]  i_req_funct3 = 3'd0;
    logic [31:0] i_req_addr = 32'd0, i_req_wdata = 32'd0;
    logic        i_mem_done = 1'b0;
    logic [31:0] i_mem_rdata = 32'd0;
    logic        o_req_ready, o_rsp_valid, o_rsp_trap, o_mem_ren, o_mem_wen;
    logic [31:0] o_rsp_rdata, o_mem_addr, o_mem_wdata;
    logic [3:0]  o_mem_mask;

    lsu_mc #(.ADDR_W(32), .MAX_WAIT(MAXW)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_we(i_req_we),
        .i_req_funct3(i_req_funct3), .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
        .o_rsp_valid(o_rsp_valid), .o_rsp_rdata(o_rsp_rdata), .o_rsp_trap(o_rsp_trap),
        .o_mem_addr(o_mem_addr), .o_mem_ren(o_mem_ren), .o_mem_wen(o_mem_wen),
        .o_mem_wdata(o_mem_wdata), .o_mem_mask(o_mem_mask),
        .i_mem_done(i_mem_done), .i_mem_rdata(i_mem_rdata)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    typedef struct { logic we; logic [31:0] addr; logic [3:0] mask; logic [31:0] wdata; } mem_exp_t;
    typedef struct { logic trap; logic [31:0] rdata; int lat; int acc; } rsp_exp_t;

    mem_exp_t    mem_q[$];
    rsp_exp_t    rsp_q[$];
    logic [7:0]  mdl_mem[int];
    logic [7:0]  dev_mem[int];
    int          lat_cfg = 0;
    int          resp_wait = 0;
    int          n_checks = 0, n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic finish_test();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    endtask

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] mdl_rd(input logic [31:0] a);
        return mdl_mem.exists(int'(a)) ? mdl_mem[int'(a)] : init_byte(a);
    endfunction

    function automatic logic [7:0] dev_rd(input logic [31:0] a);
        return dev_mem.exists(int'(a)) ? dev_mem[int'(a)] : init_byte(a);
    endfunction

    task automatic poke_word(input logic [31:0] a, input logic [31:0] d);
        for (int i = 0; i < 4; i++) begin
            mdl_mem[int'(a) + i] = d[8*i +: 8];
            dev_mem[int'(a) + i] = d[8*i +: 8];
        end
    endtask

    function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] v);
        case (f3)
            3'b000:  return {{24{v[7]}}, v[7:0]};
            3'b001:  return {{16{v[15]}}, v[15:0]};
            3'b100:  return {24'd0, v[7:0]};
            3'b101:  return {16'd0, v[15:0]};
            default: return v;
        endcase
    endfunction

    // Waits for the unit to be idle (offering junk requests meanwhile), issues one request and
    // records the expected memory beats and response.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input int lat);
        int          guard, size, nb;
        logic        illegal, err, tmo;
        logic [3:0]  m[2];
        logic [31:0] d[2], a, v;
        rsp_exp_t    r;
        mem_exp_t    e;
        guard = 0;
        @(negedge i_clk);
        while (!o_req_ready) begin
            i_req_valid  = $urandom_range(0, 1) == 1;
            i_req_we     = $urandom_range(0, 1) == 1;
            i_req_funct3 = 3'($urandom_range(0, 7));
            i_req_addr   = $urandom;
            i_req_wdata  = $urandom;
            guard++;
            if (guard > 200) begin
                chk("ready_wait_budget", 32'(guard), 32'd0);
                finish_test();
            end
            @(negedge i_clk);
        end
        size    = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (we && f3[2]);
`ifdef LSU_MISALIGNED_SPLIT_EN
        err = illegal;
`else
        err = illegal || ((addr % size) != 0);
`endif
        lat_cfg = lat;
        r.acc   = cyc;
        if (err) begin
            r.trap = 1'b1; r.rdata = 32'd0; r.lat = 2;
        end else begin
            m[0] = 4'd0; m[1] = 4'd0; d[0] = 32'd0; d[1] = 32'd0;
            for (int i = 0; i < size; i++) begin
                int k, lane;
                a    = addr + 32'(i);
                k    = ((a & ~32'd3) != (addr & ~32'd3)) ? 1 : 0;
                lane = int'(a & 32'd3);
                m[k][lane] = 1'b1;
                d[k][8*lane +: 8] = wd[8*i +: 8];
            end
            nb  = (m[1] != 4'd0) ? 2 : 1;
            tmo = (lat >= MAXW);
            e.we = we; e.addr = addr & ~32'd3; e.mask = m[0]; e.wdata = d[0];
            mem_q.push_back(e);
            if (nb == 2 && !tmo) begin
                e.addr = (addr & ~32'd3) + 32'd4; e.mask = m[1]; e.wdata = d[1];
                mem_q.push_back(e);
            end
            if (tmo) begin
                r.trap = 1'b1; r.rdata = 32'd0; r.lat = MAXW + 1;
            end else begin
                r.trap = 1'b0; r.lat = nb * (lat + 1) + 1;
                v = 32'd0;
                for (int i = 0; i < size; i++) begin
                    v[8*i +: 8] = mdl_rd(addr + 32'(i));
                    if (we) mdl_mem[int'(addr) + i] = wd[8*i +: 8];
                end
                r.rdata = we ? 32'd0 : extend(f3, v);
            end
        end
        rsp_q.push_back(r);
        i_req_valid = 1'b1; i_req_we = we; i_req_funct3 = f3; i_req_addr = addr; i_req_wdata = wd;
        @(negedge i_clk);
        i_req_valid = 1'b0;
    endtask

    // Memory side: checks every strobe cycle against the expected beat, answers after lat_cfg cycles.
    initial begin
        forever begin
            @(negedge i_clk);
            i_mem_done  = 1'b0;
            i_mem_rdata = $urandom;
            if (o_mem_ren || o_mem_wen) begin
                if (mem_q.size() == 0) begin
                    chk("mem_unexpected_strobe", {30'd0, o_mem_ren, o_mem_wen}, 32'd0);
                end else begin
                    mem_exp_t    e;
                    logic [31:0] lm;
                    e  = mem_q[0];
                    lm = {{8{e.mask[3]}}, {8{e.mask[2]}}, {8{e.mask[1]}}, {8{e.mask[0]}}};
                    chk("mem_ren", {31'd0, o_mem_ren}, {31'd0, ~e.we});
                    chk("mem_wen", {31'd0, o_mem_wen}, {31'd0, e.we});
                    chk("mem_addr", o_mem_addr, e.addr);
                    chk("mem_mask", {28'd0, o_mem_mask}, {28'd0, e.mask});
                    if (e.we) chk("mem_wdata", o_mem_wdata & lm, e.wdata);
                    if (resp_wait == lat_cfg) begin
                        for (int l = 0; l < 4; l++) begin
                            if (o_mem_wen && o_mem_mask[l]) dev_mem[int'(o_mem_addr) + l] = o_mem_wdata[8*l +: 8];
                            i_mem_rdata[8*l +: 8] = dev_rd(o_mem_addr + 32'(l));
                        end
                        i_mem_done = 1'b1;
                        void'(mem_q.pop_front());
                        resp_wait = 0;
                    end else if (resp_wait == MAXW - 1) begin
                        void'(mem_q.pop_front());
                        resp_wait = 0;
                    end else begin
                        resp_wait++;
                    end
                end
            end else begin
                resp_wait  = 0;
                i_mem_done = $urandom_range(0, 7) == 0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge i_clk);
            if (o_rsp_valid) begin
                if (rsp_q.size() == 0) begin
                    chk("rsp_unexpected", {31'd0, o_rsp_valid}, 32'd0);
                end else begin
                    rsp_exp_t e;
                    e = rsp_q.pop_front();
                    chk("rsp_trap", {31'd0, o_rsp_trap}, {31'd0, e.trap});
                    chk("rsp_rdata", o_rsp_rdata, e.rdata);
                    chk("rsp_latency", 32'(cyc - e.acc), 32'(e.lat));
                end
            end
        end
    end

    initial begin
        int guard;
        repeat (3) @(negedge i_clk);
        chk("rst_ready", {31'd0, o_req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", o_rsp_rdata, 32'd0);
        chk("rst_rsp_trap", {31'd0, o_rsp_trap}, 32'd0);
        chk("rst_strobes", {30'd0, o_mem_ren, o_mem_wen}, 32'd0);
        chk("rst_mem_addr", o_mem_addr, 32'd0);
        chk("rst_mem_mask", {28'd0, o_mem_mask}, 32'd0);
        chk("rst_mem_wdata", o_mem_wdata, 32'd0);
        i_rst = 1'b0;

        poke_word(32'h1000, 32'hDEADBEEF);
        poke_word(32'h2000, 32'h80000000);
        issue(1'b0, 3'b010, 32'h1000, 32'd0, 2);
        issue(1'b0, 3'b000, 32'h2003, 32'd0, 0);
        issue(1'b0, 3'b100, 32'h2003, 32'd0, 1);
        issue(1'b1, 3'b001, 32'h3002, 32'h1234ABCD, 1);
        issue(1'b0, 3'b101, 32'h3002, 32'd0, 0);
        poke_word(32'h1000, 32'h44332211);
        poke_word(32'h1004, 32'h88776655);
        issue(1'b0, 3'b010, 32'h1001, 32'd0, 0);
        issue(1'b0, 3'b001, 32'h1003, 32'd0, 1);
        issue(1'b0, 3'b010, 32'h1000, 32'd0, NEVER);
        issue(1'b1, 3'b010, 32'h1004, 32'hCAFEF00D, NEVER);
        issue(1'b0, 3'b010, 32'h1004, 32'd0, MAXW - 1);
        issue(1'b0, 3'b011, 32'h1000, 32'd0, 0);
        issue(1'b1, 3'b100, 32'h1000, 32'd0, 0);

        issue(1'b0, 3'b010, 32'h1000, 32'd0, NEVER);
        @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        chk("midrst_ready", {31'd0, o_req_ready}, 32'd1);
        chk("midrst_strobes", {30'd0, o_mem_ren, o_mem_wen}, 32'd0);
        chk("midrst_rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
        rsp_q.delete();
        mem_q.delete();
        i_rst = 1'b0;
        repeat (4) @(negedge i_clk);

        for (int n = 0; n < 250; n++) begin
            int lat;
            lat = ($urandom_range(0, 9) == 0) ? NEVER : int'($urandom_range(0, 3));
            issue($urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)),
                  32'h100 + 32'($urandom_range(0, 47)), $urandom, lat);
        end

        guard = 0;
        while ((rsp_q.size() != 0 || !o_req_ready) && guard < 100) begin
            @(negedge i_clk);
            guard++;
        end
        repeat (3) @(negedge i_clk);
        chk("rsp_queue_drained", 32'(rsp_q.size()), 32'd0);
        chk("mem_queue_drained", 32'(mem_q.size()), 32'd0);
        finish_test();
    end

endmodule

// File: doc/lsu_mc.md
Name: lsu_mc

Overview:
- Multi-cycle load/store unit that replaces the combinational dmem path of the single-cycle hart for later phases.
- Accepts one load/store request per transaction from execute over a valid/ready handshake.
- Drives a variable-latency data memory port with word-aligned addresses and byte masks.
- Returns a registered, sign/zero-extended response or a trap. Parametrised in address width and bus timeout.

Parameters:
- ADDR_W, 32, width of request and memory addresses (>=3).
- MAX_WAIT, 0, max cycles waiting on i_mem_done before timeout trap; 0 disables timeout.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous active-high reset.
- i_req_valid  in  1  request valid.
- o_req_ready  out  1  unit idle, can accept.
- i_req_we  in  1  1=store, 0=load.
- i_req_funct3  in  3  RV32I load/store funct3 (size + unsigned).
- i_req_addr  in  ADDR_W  byte address.
- i_req_wdata  in  32  store data, right-justified.
- o_rsp_valid  out  1  one-cycle response pulse.
- o_rsp_rdata  out  32  extended load data; 0 for stores/traps.
- o_rsp_trap  out  1  misaligned, illegal funct3, or timeout.
- o_mem_addr  out  ADDR_W  word-aligned address (two LSBs zero).
- o_mem_ren  out  1  read strobe, held until done.
- o_mem_wen  out  1  write strobe, held until done; never with ren.
- o_mem_wdata  out  32  lane-shifted store data.
- o_mem_mask  out  4  byte-lane enables.
- i_mem_done  in  1  access complete this cycle; rdata valid if read.
- i_mem_rdata  in  32  read data, valid with i_mem_done.

Behaviour:
- Reset: state IDLE; o_req_ready=1; o_rsp_valid=0, o_rsp_rdata=0, o_rsp_trap=0; o_mem_ren=o_mem_wen=0, o_mem_addr=0, o_mem_mask=0, o_mem_wdata=0; wait counter=0.
- Accept on i_req_valid & o_req_ready. Latch we, funct3, addr and wdata. o_req_ready falls the next cycle and stays low until the cycle after o_rsp_valid.
- States:
  - IDLE, accept, then:
    - ERR if illegal: funct3 in {011,110,111}, or store with funct3[2]=1.
    - ERR if misaligned: half with addr[0]=1, or word with addr[1:0]!=0.
    - otherwise ACC1.
  - ACC1: strobe asserted, registered outputs. On i_mem_done go to RESP, or to ACC2 when split (optional feature).
  - ACC2: second beat. On i_mem_done go to RESP.
  - ERR: one cycle, then RESP with trap=1. No memory strobe is ever asserted.
  - RESP: o_rsp_valid=1 for exactly one cycle, then IDLE.
- Minimum latency: accept at cycle N, strobe N+1, done N+1, o_rsp_valid N+2.
- Masks: byte 0001<<off; half 0011<<off; word 1111. Here off=addr[1:0]. Store wdata is shifted left by 8*off.
- Load: shift rdata right by 8*off, then sign-extend (funct3[2]=0) or zero-extend (funct3[2]=1) at size.
- Timeout (MAX_WAIT>0): counter clears on entry to ACC1/ACC2 and increments each cycle without i_mem_done. When it reaches MAX_WAIT: drop the strobe, go to RESP, trap=1, rdata=0. A done arriving in the same cycle as the limit wins, with no trap.
- i_mem_done outside ACC1/ACC2 is ignored.
- New i_req_valid while busy is not accepted.
- i_rst mid-transaction: immediate return to reset values, strobe dropped, no response.

Optional Feature:
- LSU_MISALIGNED_SPLIT_EN defined: a misaligned half/word access is not trapped. It splits into two beats:
  - beat 1: word addr, mask = (sizemask<<off)[3:0], wdata<<8*off.
  - beat 2: addr+4, mask = (sizemask<<off)[7:4], wdata>>(32-8*off).
  - Load data is {beat2, beat1} shifted right by 8*off, then extended.
  - Beat 1 data is held in a 32-bit register.
  - Timeout in either beat traps. Beat-1 writes are not rolled back.
- Not defined: ACC2 and the beat register are not present; misaligned accesses trap via ERR.

Decomposition:
- Shared package lsu_pkg:
  - funct3 constants (LB/LH/LW/LBU/LHU, SB/SH/SW);
  - state enum (IDLE, ACC1, ACC2, ERR, RESP);
  - size-to-mask constants.
- One sub-module lsu_align: combinational lane shift, mask generation and load extension. Shared by both beats.

Test Plan:
- lw 0x1000, memory returns 0xDEADBEEF after 3 cycles:
  - mem_addr=0x1000, mask=1111 held 3 cycles;
  - rsp_rdata=0xDEADBEEF, trap=0, one rsp pulse.
- lb 0x2003 with rdata=0x80000000 → mask=1000, rsp=0xFFFFFF80.
- lbu 0x2003 with rdata=0x80000000 → rsp=0x00000080.
- sh 0x3002 with wdata=0x1234ABCD → mem_wen, addr=0x3000, mask=1100, wdata[31:16]=0xABCD.
- lw 0x1001:
  - without split: no strobe, rsp trap=1 two cycles after accept.
  - with split, beats 0x1000/1110 and 0x1004/0001 returning 0x44332211, 0x88776655 → rsp=0x55443322.
- MAX_WAIT=4, done never asserted → strobe drops after 4 cycles, rsp trap=1, rdata=0. Separately, i_rst during ACC1 → ready=1 next cycle, no rsp.
